l2_home_responder: RTL and testbench
====================================

// Module: l2_home_responder
// PURPOSE
//  Home-node responder at the far end of the L2 request channel: accepts L2 outgoing requests
//  (req_out) and returns the matching response on the L2 response-in channel (rsp_in).
//  Holds a small direct-mapped line store as the backing image. Used as the LLC stand-in for
//  L2 block-level benches and single-tile FPGA bring-up. One request in flight, no forwards.
// PARAMETERS
//  WORDS_PER_LINE  4   words per cache line (word_mask width)
//  WORD_W          64  bits per word; LINE_W = WORDS_PER_LINE*WORD_W
//  LINE_ADDR_W     28  line address width
//  IDX_BITS        6   store index bits; store depth = 2**IDX_BITS lines
// PORTS
//  clk              in   1        clock
//  rst              in   1        synchronous, active-high reset
//  req_valid        in   1        L2 request valid
//  req_ready        out  1        responder accepts request this cycle
//  req_coh_msg      in   3        request message code (spandex_consts)
//  req_hprot        in   1        hprot (ignored; carried for protocol checking)
//  req_addr         in   LINE_ADDR_W  line address
//  req_line         in   LINE_W   write data (WT/WB/Odata-with-data)
//  req_word_mask    in   WORDS_PER_LINE  words addressed by request
//  rsp_valid        out  1        response valid
//  rsp_ready        in   1        L2 accepts response
//  rsp_coh_msg      out  3        response message code
//  rsp_addr         out  LINE_ADDR_W  echoed request address
//  rsp_line         out  LINE_W   response data (zero for ack-only responses)
//  rsp_word_mask    out  WORDS_PER_LINE  echoed request word_mask
//  init_done        out  1        store clear complete after reset
// BEHAVIOUR
//  Reset: all outputs 0; FSM -> INIT; init counter = 0. Reset mid-transaction drops it silently.
//  FSM: INIT -> IDLE -> RD -> RSP -> IDLE.
//   INIT: writes zero line to index cnt each cycle; cnt==depth-1 -> IDLE, init_done=1 (sticky).
//   IDLE: req_ready=1; on req_valid&req_ready latch all req fields -> RD.
//   RD:   synchronous store read of latched index (low IDX_BITS of addr; upper bits ignored,
//         aliasing accepted); apply message action; -> RSP with rsp_* registered.
//   RSP:  rsp_valid=1, all rsp_* stable until rsp_valid&rsp_ready -> IDLE.
//  req_ready is 0 in INIT, RD, RSP (no pipelining; no skid buffer).
//  Latency: request accepted cycle T -> rsp_valid first asserted cycle T+2; next request
//   accepted no earlier than handshake cycle +1.
//  Message actions (req -> rsp):
//   REQ_V     -> RSP_V,     rsp_line = stored line, masked words only, others 0
//   REQ_S     -> RSP_S,     rsp_line = full stored line
//   REQ_Odata -> RSP_Odata, rsp_line = full stored line
//   REQ_O     -> RSP_O,     rsp_line = 0
//   REQ_WT    -> RSP_O,     store word i <- req_line word i where mask[i]; rsp_line = 0
//   REQ_WB    -> RSP_WB_ACK, same masked write as REQ_WT; rsp_line = 0
//   other     -> RSP_NACK,  no store update, rsp_line = 0
//  Write and read of same index never collide: single request, write committed in RD.
//  word_mask == 0 on a write: no store change, ack still sent.
//  rsp_ready held low indefinitely: FSM stays in RSP; no timeout.
// STRUCTURE
//  Message codes, REQ_*/RSP_* constants and WORDS_PER_LINE/WORD_W live in spandex_consts.svh;
//  word_mask_t, line_t, line_addr_t in spandex_types.svh. FSM state enum is local.
//  One sub-module: l2_home_store (depth x LINE_W, per-word write enable, 1-cycle sync read).
// TESTING
//  1 Reset release -> req_ready=0 for 64 cycles, init_done rises cycle 64, then req_ready=1.
//  2 REQ_S addr 0x10 after reset -> RSP_S at T+2, rsp_line=0, rsp_addr=0x10, mask echoed 4'hF.
//  3 REQ_WT addr 0x10 mask 4'b0101 line {D,C,B,A} -> RSP_O; then REQ_S -> line {0,C,0,A}.
//  4 REQ_V addr 0x10 mask 4'b0001 -> RSP_V, rsp_line={0,0,0,A}; addr 0x50 aliases, same data.
//  5 Hold rsp_ready=0 for 10 cycles -> rsp_* stable, req_ready=0; release -> IDLE next cycle.
//  6 rst pulsed while in RSP -> rsp_valid=0 next cycle, INIT rerun, store reads back 0.

Source files
------------

// File: rtl/l2_home_responder_pkg.sv
// Shared widths, message codes and helpers for the L2 home-node responder.
package l2_home_responder_pkg;

    localparam int unsigned WORDS_PER_LINE = 4;
    localparam int unsigned WORD_W         = 64;
    localparam int unsigned LINE_W         = WORDS_PER_LINE * WORD_W;
    localparam int unsigned LINE_ADDR_W    = 28;
    localparam int unsigned IDX_BITS       = 6;
    localparam int unsigned STORE_DEPTH    = 1 << IDX_BITS;
    localparam int unsigned MSG_W          = 3;

    typedef logic [WORDS_PER_LINE-1:0] word_mask_t;
    typedef logic [LINE_W-1:0]         line_t;
    typedef logic [LINE_ADDR_W-1:0]    line_addr_t;
    typedef logic [MSG_W-1:0]          coh_msg_t;

    // Request message codes
    localparam coh_msg_t REQ_V      = 3'b000;
    localparam coh_msg_t REQ_S      = 3'b001;
    localparam coh_msg_t REQ_WT     = 3'b010;
    localparam coh_msg_t REQ_O      = 3'b011;
    localparam coh_msg_t REQ_WB     = 3'b100;
    localparam coh_msg_t REQ_ODATA  = 3'b101;

    // Response message codes
    localparam coh_msg_t RSP_S      = 3'b000;
    localparam coh_msg_t RSP_ODATA  = 3'b001;
    localparam coh_msg_t RSP_V      = 3'b010;
    localparam coh_msg_t RSP_O      = 3'b011;
    localparam coh_msg_t RSP_WB_ACK = 3'b100;
    localparam coh_msg_t RSP_NACK   = 3'b101;

    // Keep only the words selected by mask, zero the rest.
    function automatic line_t mask_line(input line_t line, input word_mask_t mask);
        line_t res;
        res = '0;
        for (int w = 0; w < int'(WORDS_PER_LINE); w++) begin
            if (mask[w]) res[w*WORD_W +: WORD_W] = line[w*WORD_W +: WORD_W];
        end
        return res;
    endfunction

endpackage

// File: rtl/l2_home_responder_store.sv
// Direct-mapped line store: per-word write enable, one-cycle synchronous read.
module l2_home_responder_store
    import l2_home_responder_pkg::*;
(
    input  logic                clk,
    input  logic [IDX_BITS-1:0] i_wr_idx,
    input  logic [WORDS_PER_LINE-1:0] i_wr_mask,
    input  logic [LINE_W-1:0]   i_wr_data,
    input  logic [IDX_BITS-1:0] i_rd_idx,
    output logic [LINE_W-1:0]   o_rd_data
);

    logic [LINE_W-1:0] r_mem [STORE_DEPTH];
    logic [LINE_W-1:0] r_rd_data;

    // Masked word writes and registered read (read returns pre-write contents).
    always_ff @(posedge clk) begin
        for (int w = 0; w < int'(WORDS_PER_LINE); w++) begin
            if (i_wr_mask[w]) r_mem[i_wr_idx][w*WORD_W +: WORD_W] <= i_wr_data[w*WORD_W +: WORD_W];
        end
        r_rd_data <= r_mem[i_rd_idx];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/l2_home_responder.sv
// L2 home-node responder: one request in flight, backed by a small line store.
module l2_home_responder
    import l2_home_responder_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [MSG_W-1:0]          req_coh_msg,
    input  logic                      req_hprot,
    input  logic [LINE_ADDR_W-1:0]    req_addr,
    input  logic [LINE_W-1:0]         req_line,
    input  logic [WORDS_PER_LINE-1:0] req_word_mask,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [MSG_W-1:0]          rsp_coh_msg,
    output logic [LINE_ADDR_W-1:0]    rsp_addr,
    output logic [LINE_W-1:0]         rsp_line,
    output logic [WORDS_PER_LINE-1:0] rsp_word_mask,
    output logic                      init_done
);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_RD, ST_RSP} state_t;

    state_t        r_state;
    logic [IDX_BITS-1:0] r_cnt;
    coh_msg_t      r_msg;
    line_addr_t    r_addr;
    line_t         r_line;
    word_mask_t    r_mask;
    logic          r_req_ready;
    logic          r_rsp_valid;
    coh_msg_t      r_rsp_msg;
    line_addr_t    r_rsp_addr;
    line_t         r_rsp_line;
    word_mask_t    r_rsp_mask;
    logic          r_init_done;

    logic                w_init;
    logic                w_wr_req;
    logic [IDX_BITS-1:0] w_wr_idx;
    word_mask_t          w_wr_mask;
    line_t               w_wr_data;
    logic [IDX_BITS-1:0] w_rd_idx;
    line_t               w_rd_data;
    logic                w_unused_hprot;

    // hprot is only carried for protocol checking upstream.
    assign w_unused_hprot = req_hprot;

    // Store port steering: clear during INIT, masked write in RD, read addressed at accept.
    assign w_init    = (r_state == ST_INIT);
    assign w_wr_req  = (r_state == ST_RD) && ((r_msg == REQ_WT) || (r_msg == REQ_WB));
    assign w_wr_idx  = w_init ? r_cnt : r_addr[IDX_BITS-1:0];
    assign w_wr_mask = w_init ? '1 : (w_wr_req ? r_mask : '0);
    assign w_wr_data = w_init ? '0 : r_line;
    assign w_rd_idx  = (r_state == ST_IDLE) ? req_addr[IDX_BITS-1:0] : r_addr[IDX_BITS-1:0];

    l2_home_responder_store u_store (
        .clk       (clk),
        .i_wr_idx  (w_wr_idx),
        .i_wr_mask (w_wr_mask),
        .i_wr_data (w_wr_data),
        .i_rd_idx  (w_rd_idx),
        .o_rd_data (w_rd_data)
    );

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_INIT;
            r_cnt       <= '0;
            r_msg       <= '0;
            r_addr      <= '0;
            r_line      <= '0;
            r_mask      <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_msg   <= '0;
            r_rsp_addr  <= '0;
            r_rsp_line  <= '0;
            r_rsp_mask  <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_cnt <= r_cnt + IDX_BITS'(1);
                    if (r_cnt == IDX_BITS'(STORE_DEPTH - 1)) begin
                        r_state     <= ST_IDLE;
                        r_init_done <= 1'b1;
                        r_req_ready <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_msg       <= req_coh_msg;
                        r_addr      <= req_addr;
                        r_line      <= req_line;
                        r_mask      <= req_word_mask;
                        r_req_ready <= 1'b0;
                        r_state     <= ST_RD;
                    end
                end
                ST_RD: begin
                    r_rsp_addr  <= r_addr;
                    r_rsp_mask  <= r_mask;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RSP;
                    case (r_msg)
                        REQ_V: begin
                            r_rsp_msg  <= RSP_V;
                            r_rsp_line <= mask_line(w_rd_data, r_mask);
                        end
                        REQ_S: begin
                            r_rsp_msg  <= RSP_S;
                            r_rsp_line <= w_rd_data;
                        end
                        REQ_ODATA: begin
                            r_rsp_msg  <= RSP_ODATA;
                            r_rsp_line <= w_rd_data;
                        end
                        REQ_O, REQ_WT: begin
                            r_rsp_msg  <= RSP_O;
                            r_rsp_line <= '0;
                        end
                        REQ_WB: begin
                            r_rsp_msg  <= RSP_WB_ACK;
                            r_rsp_line <= '0;
                        end
                        default: begin
                            r_rsp_msg  <= RSP_NACK;
                            r_rsp_line <= '0;
                        end
                    endcase
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_coh_msg   = r_rsp_msg;
    assign rsp_addr      = r_rsp_addr;
    assign rsp_line      = r_rsp_line;
    assign rsp_word_mask = r_rsp_mask;
    assign init_done     = r_init_done;

endmodule

// File: tb/tb_l2_home_responder.sv
// Directed bench for the L2 home-node responder.
module tb_l2_home_responder;
    import l2_home_responder_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0;
    logic req_ready;
    logic [2:0] req_coh_msg = '0;
    logic req_hprot = 1'b0;
    logic [27:0] req_addr = '0;
    logic [255:0] req_line = '0;
    logic [3:0] req_word_mask = '0;
    logic rsp_valid;
    logic rsp_ready = 1'b0;
    logic [2:0] rsp_coh_msg;
    logic [27:0] rsp_addr;
    logic [255:0] rsp_line;
    logic [3:0] rsp_word_mask;
    logic init_done;

    int n_checks = 0;
    int n_fail = 0;

    localparam logic [63:0] WA = 64'hA0A0_A0A0_0000_000A;
    localparam logic [63:0] WB = 64'hB0B0_B0B0_0000_000B;
    localparam logic [63:0] WC = 64'hC0C0_C0C0_0000_000C;
    localparam logic [63:0] WD = 64'hD0D0_D0D0_0000_000D;
    localparam logic [63:0] WE = 64'hE0E0_E0E0_0000_000E;
    localparam logic [63:0] W0 = 64'h0;

    always #5 clk = ~clk;

    l2_home_responder dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_coh_msg   (req_coh_msg),
        .req_hprot     (req_hprot),
        .req_addr      (req_addr),
        .req_line      (req_line),
        .req_word_mask (req_word_mask),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_coh_msg   (rsp_coh_msg),
        .rsp_addr      (rsp_addr),
        .rsp_line      (rsp_line),
        .rsp_word_mask (rsp_word_mask),
        .init_done     (init_done)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Wait for req_ready, present one request, return edges from accept to rsp_valid.
    task automatic issue(input logic [2:0] msg, input logic [27:0] addr,
                         input logic [255:0] line, input logic [3:0] mask, output int lat);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_ready got %b exp 1", req_ready);
        end
        req_valid = 1'b1;
        req_coh_msg = msg;
        req_addr = addr;
        req_line = line;
        req_word_mask = mask;
        step();
        req_valid = 1'b0;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 50) begin
            step();
            lat++;
        end
    endtask

    // Complete the response handshake and leave rsp_ready low.
    task automatic finish_rsp;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        int bad;
        rst = 1'b1;
        repeat (3) step();
        n_checks++;
        if ({req_ready, rsp_valid, rsp_coh_msg, rsp_addr, rsp_line, rsp_word_mask, init_done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got rdy=%b vld=%b done=%b line=%h", req_ready, rsp_valid, init_done, rsp_line);
        end
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (req_ready !== 1'b0 || init_done !== 1'b0) bad++;
            step();
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL init_busy got %0d cycles ready/done early exp 0", bad);
        end
        n_checks++;
        if ({init_done, req_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL init_done_at_64 got done=%b rdy=%b exp 1 1", init_done, req_ready);
        end
    endtask

    // Issue one request and compare the full response plus latency.
    task automatic test_txn(input string name, input logic [2:0] msg, input logic [27:0] addr,
                            input logic [255:0] line, input logic [3:0] mask,
                            input logic [2:0] exp_msg, input logic [255:0] exp_line);
        int lat;
        issue(msg, addr, line, mask, lat);
        n_checks++;
        if (lat != 1) begin
            n_fail++;
            $display("FAIL %s_latency got %0d exp 1", name, lat);
        end
        n_checks++;
        if ({rsp_coh_msg, rsp_addr, rsp_word_mask, rsp_line} !== {exp_msg, addr, mask, exp_line}) begin
            n_fail++;
            $display("FAIL %s_rsp got msg=%h addr=%h mask=%h line=%h exp msg=%h addr=%h mask=%h line=%h",
                     name, rsp_coh_msg, rsp_addr, rsp_word_mask, rsp_line, exp_msg, addr, mask, exp_line);
        end
        finish_rsp();
        n_checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL %s_handshake got vld=%b rdy=%b exp 0 1", name, rsp_valid, req_ready);
        end
    endtask

    task automatic test_messages;
        test_txn("s_clear",  REQ_S,  28'h10, '1, 4'hF, RSP_S, '0);
        test_txn("wt",       REQ_WT, 28'h10, {WD, WC, WB, WA}, 4'b0101, RSP_O, '0);
        test_txn("s_wt",     REQ_S,  28'h10, '0, 4'hF, RSP_S, {W0, WC, W0, WA});
        test_txn("v",        REQ_V,  28'h10, '0, 4'b0001, RSP_V, {W0, W0, W0, WA});
        test_txn("v_alias",  REQ_V,  28'h50, '0, 4'b0001, RSP_V, {W0, W0, W0, WA});
        test_txn("wb",       REQ_WB, 28'h10, {WE, WE, WE, WE}, 4'b1000, RSP_WB_ACK, '0);
        test_txn("odata",    REQ_ODATA, 28'h10, '0, 4'b0011, RSP_ODATA, {WE, WC, W0, WA});
        test_txn("v_1010",   REQ_V,  28'h10, '0, 4'b1010, RSP_V, {WE, W0, W0, W0});
        test_txn("wt_mask0", REQ_WT, 28'h10, {WB, WB, WB, WB}, 4'b0000, RSP_O, '0);
        test_txn("o",        REQ_O,  28'h10, {WB, WB, WB, WB}, 4'hF, RSP_O, '0);
        test_txn("nack",     3'b111, 28'h10, {WD, WD, WD, WD}, 4'hF, RSP_NACK, '0);
        test_txn("s_after",  REQ_S,  28'h10, '0, 4'hF, RSP_S, {WE, WC, W0, WA});
        test_txn("s_other",  REQ_S,  28'h11, '0, 4'hF, RSP_S, '0);
    endtask

    task automatic test_backpressure;
        int lat;
        int bad;
        issue(REQ_S, 28'h0450, '0, 4'b1100, lat);
        n_checks++;
        if (lat != 1) begin
            n_fail++;
            $display("FAIL bp_latency got %0d exp 1", lat);
        end
        req_valid = 1'b1;
        req_coh_msg = REQ_WT;
        req_addr = 28'h10;
        req_line = '1;
        req_word_mask = 4'hF;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_coh_msg !== RSP_S ||
                rsp_addr !== 28'h0450 || rsp_word_mask !== 4'b1100 || rsp_line !== {WE, WC, W0, WA}) bad++;
        end
        req_valid = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_hold got %0d unstable cycles exp 0 (line=%h)", bad, rsp_line);
        end
        finish_rsp();
        n_checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_release got vld=%b rdy=%b exp 0 1", rsp_valid, req_ready);
        end
        test_txn("s_bp_after", REQ_S, 28'h10, '0, 4'hF, RSP_S, {WE, WC, W0, WA});
    endtask

    task automatic test_reset_in_rsp;
        int lat;
        int n;
        issue(REQ_S, 28'h10, '0, 4'hF, lat);
        rst = 1'b1;
        step();
        n_checks++;
        if ({rsp_valid, req_ready, init_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_rsp got vld=%b rdy=%b done=%b exp 0 0 0", rsp_valid, req_ready, init_done);
        end
        rst = 1'b0;
        n = 0;
        while (init_done !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        n_checks++;
        if (n != 64) begin
            n_fail++;
            $display("FAIL rst_reinit got %0d cycles exp 64", n);
        end
        test_txn("s_reinit", REQ_S, 28'h10, '0, 4'hF, RSP_S, '0);
    endtask

    initial begin
        test_reset();
        test_messages();
        test_backpressure();
        test_reset_in_rsp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
